// File: rtl/sha512_pre_arb.sv
// sha512_pre_arb: round-robin message-granular arbiter feeding one SHA-512 pre-processing engine.
// Define SHA512_PRE_ARB_STATS_EN to add the o_msg_cnt completed-message counter.
module sha512_pre_arb #(
  parameter int N_REQ = 4,
  parameter int W_M = 64,
  parameter int MAX_BEATS = 32,
  localparam int SW = $clog2(N_REQ),
  localparam int BW = $clog2(MAX_BEATS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   i_v,
  input  logic [N_REQ-1:0]   i_e,
  input  logic [N_REQ*W_M-1:0] i_m,
  output logic [N_REQ-1:0]   i_r,
  output logic               o_v,
  output logic               o_e,
  output logic [W_M-1:0]     o_m,
  output logic [SW-1:0]      o_src,
  input  logic               o_w,
  output logic               o_err
`ifdef SHA512_PRE_ARB_STATS_EN
  , output logic [31:0]      o_msg_cnt
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, src_q, src_d, sel;
  logic [SW:0] idx;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [W_M-1:0] m_q, m_d;
  logic v_q, v_d, e_q, e_d, err_q, err_d, rdy, acc, sat;
  // first requesting lane at or after ptr, wrapping modulo N_REQ
  always_comb begin
    sel = ptr_q;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (SW + 1)'(k);
      if (idx >= (SW + 1)'(N_REQ)) idx = idx - (SW + 1)'(N_REQ);
      if (i_v[idx[SW-1:0]]) sel = idx[SW-1:0];
    end
  end
  assign rdy = (state_q == BUSY) & (~v_q | ~o_w);
  assign acc = rdy & i_v[gnt_q];
  assign sat = bcnt_q == BW'(MAX_BEATS);
  assign i_r = rdy ? N_REQ'(1) << gnt_q : '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    bcnt_d = bcnt_q;
    err_d = err_q;
    v_d = acc | (v_q & o_w);
    e_d = acc ? i_e[gnt_q] : e_q;
    m_d = acc ? i_m[gnt_q*W_M +: W_M] : m_q;
    src_d = acc ? gnt_q : src_q;
    if (state_q == IDLE) begin
      if (|i_v) begin
        gnt_d = sel;
        bcnt_d = '0;
        state_d = BUSY;
      end
    end else if (acc) begin
      bcnt_d = sat ? bcnt_q : bcnt_q + 1'b1;
      err_d = err_q | (sat & ~i_e[gnt_q]);
      if (i_e[gnt_q]) begin
        ptr_d = (gnt_q == SW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      bcnt_q <= '0;
      v_q <= 1'b0;
      e_q <= 1'b0;
      m_q <= '0;
      src_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      bcnt_q <= bcnt_d;
      v_q <= v_d;
      e_q <= e_d;
      m_q <= m_d;
      src_q <= src_d;
      err_q <= err_d;
    end
  end
  assign o_v = v_q;
  assign o_e = e_q;
  assign o_m = m_q;
  assign o_src = src_q;
  assign o_err = err_q;
`ifdef SHA512_PRE_ARB_STATS_EN
  logic [31:0] msg_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) msg_cnt_q <= '0;
    else if (acc & i_e[gnt_q]) msg_cnt_q <= msg_cnt_q + 32'd1;
  end
  assign o_msg_cnt = msg_cnt_q;
`endif
endmodule
